// File: rtl/mul_iterative_param.sv
// mul_iterative_param
// Iterative RV32M/RV64M multiplier (MUL, MULH, MULHSU, MULHU) for the execute
// stage. Operands are turned into unsigned magnitudes, multiplied by
// shift-and-add BITS_PER_CYCLE multiplier bits per cycle, and the sign is put
// back in one final cycle.
//
// Ports
//   clk             : clock
//   rst             : asynchronous, active-high reset
//   startE          : request a multiply; only looked at in IDLE
//   flush           : abort the operation in flight; wins over startE
//   mul_opcode      : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   operand1/2      : rs1 / rs2, captured on the accepting edge
//   result_multiply : registered result, held until the next completion
//   done            : registered one-cycle completion pulse
//   mul_use         : combinational stall request to the pipeline
//   fsm_state       : current state (0 IDLE, 1 BUSY, 2 FIX) for observation
//
// Handshake: a request is taken on the edge where startE=1, flush=0 and the
// block is IDLE; mul_use is high from that cycle through the FIX cycle, so the
// pipeline holds the instruction until done. There is no queueing: startE
// outside IDLE is ignored.
module mul_iterative_param #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic            flush,
  input  logic [1:0]      mul_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic [XLEN-1:0] result_multiply,
  output logic            done,
  output logic            mul_use,
  output logic [1:0]      fsm_state
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER);
  localparam int PW    = 2 * XLEN;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  generate
    if ((XLEN != 32 && XLEN != 64) ||
        (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) ||
        (XLEN % BITS_PER_CYCLE != 0)) begin : g_bad_params
      $error("mul_iterative_param: unsupported XLEN/BITS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [1:0]       op_q;
  logic             neg_q;
  logic [PW-1:0]    mcand_sh;
  logic [XLEN-1:0]  mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] counter;

  logic             accept;
  logic             last_iter;
  logic             s1;
  logic             s2;
  logic [XLEN-1:0]  mag1;
  logic [XLEN-1:0]  mag2;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    product;

  assign accept    = (state == S_IDLE) && startE && !flush;
  assign last_iter = (counter == CNT_W'(ITER - 1));

  // Only the "signed" operands of each opcode contribute a sign.
  assign s1   = ((mul_opcode == OP_MULH) || (mul_opcode == OP_MULHSU)) && operand1[XLEN-1];
  assign s2   = (mul_opcode == OP_MULH) && operand2[XLEN-1];
  // Negating the most-negative value yields 2^(XLEN-1), which is exactly the
  // right magnitude when read as unsigned XLEN bits.
  assign mag1 = s1 ? -operand1 : operand1;
  assign mag2 = s2 ? -operand2 : operand2;

  // The multiplicand is pre-shifted by BITS_PER_CYCLE every iteration, which
  // is the same as shifting each partial product by counter*BITS_PER_CYCLE.
  assign partial = mcand_sh * PW'(mplier[BITS_PER_CYCLE-1:0]);
  assign product = neg_q ? -acc : acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_BUSY;
      S_BUSY: begin
        if (flush)          state_next = S_IDLE;
        else if (last_iter) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mul_use   = accept || (state == S_BUSY) || (state == S_FIX);
    fsm_state = state;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q            <= OP_MUL;
      neg_q           <= 1'b0;
      mcand_sh        <= '0;
      mplier          <= '0;
      acc             <= '0;
      counter         <= '0;
      result_multiply <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= mul_opcode;
            neg_q    <= s1 ^ s2;
            mcand_sh <= {{XLEN{1'b0}}, mag1};
            mplier   <= mag2;
            acc      <= '0;
            counter  <= '0;
          end
        end
        S_BUSY: begin
          if (!flush) begin
            acc      <= acc + partial;
            mcand_sh <= mcand_sh << BITS_PER_CYCLE;
            mplier   <= mplier >> BITS_PER_CYCLE;
            counter  <= counter + CNT_W'(1);
          end
        end
        S_FIX: begin
          // A flush here drops the result: no done, old result kept.
          if (!flush) begin
            result_multiply <= (op_q == OP_MUL) ? product[XLEN-1:0] : product[PW-1:XLEN];
            done            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iterative_param.sv
// tb_mul_iterative_param
// Bench for mul_iterative_param. Four instances: XLEN=32 with BITS_PER_CYCLE
// 1/2/4, and XLEN=64 with BITS_PER_CYCLE 2. Directed steps exercise dut0;
// the random sweep runs all four in lockstep. Expected results and done cycles
// are queued when a request is driven and checked when done appears.
module tb_mul_iterative_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // ---------------- DUT signals ----------------
  logic        start0  = 1'b0;
  logic        start_s = 1'b0;
  logic        flush   = 1'b0;
  logic [1:0]  opc     = 2'b00;
  logic [63:0] opa     = '0;
  logic [63:0] opb     = '0;

  logic [31:0] res0, res1, res2;
  logic [63:0] res3;
  logic        done0, done1, done2, done3;
  logic        use0, use1, use2, use3;
  logic [1:0]  st0, st1, st2, st3;

  mul_iterative_param #(.XLEN(32), .BITS_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst(rst), .startE(start0), .flush(flush), .mul_opcode(opc),
    .operand1(opa[31:0]), .operand2(opb[31:0]), .result_multiply(res0),
    .done(done0), .mul_use(use0), .fsm_state(st0));
  mul_iterative_param #(.XLEN(32), .BITS_PER_CYCLE(2)) dut1 (
    .clk(clk), .rst(rst), .startE(start_s), .flush(flush), .mul_opcode(opc),
    .operand1(opa[31:0]), .operand2(opb[31:0]), .result_multiply(res1),
    .done(done1), .mul_use(use1), .fsm_state(st1));
  mul_iterative_param #(.XLEN(32), .BITS_PER_CYCLE(4)) dut2 (
    .clk(clk), .rst(rst), .startE(start_s), .flush(flush), .mul_opcode(opc),
    .operand1(opa[31:0]), .operand2(opb[31:0]), .result_multiply(res2),
    .done(done2), .mul_use(use2), .fsm_state(st2));
  mul_iterative_param #(.XLEN(64), .BITS_PER_CYCLE(2)) dut3 (
    .clk(clk), .rst(rst), .startE(start_s), .flush(flush), .mul_opcode(opc),
    .operand1(opa), .operand2(opb), .result_multiply(res3),
    .done(done3), .mul_use(use3), .fsm_state(st3));

  // ---------------- scoreboard ----------------
  // Entry = {expected done cycle[31:0], expected result[63:0]}
  logic [95:0] exp_q0[$];
  logic [95:0] exp_q1[$];
  logic [95:0] exp_q2[$];
  logic [95:0] exp_q3[$];

  int tests = 0;
  int fails = 0;
  int done_cnt0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: sign-extend each operand per opcode and take the full product.
  function automatic logic [63:0] model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? {32'b0, p[31:0]} : {32'b0, p[63:32]};
  endfunction

  function automatic logic [63:0] model64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_8000_0000;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- monitors ----------------
  logic [95:0] e0, e1, e2, e3;
  logic pd0 = 1'b0, pd1 = 1'b0, pd2 = 1'b0, pd3 = 1'b0;

  always @(negedge clk) begin
    if (done0) begin
      done_cnt0++;
      chk("dut0 done single-cycle", 64'(pd0), 64'd0);
      chk("dut0 done expected", 64'(exp_q0.size() != 0), 64'd1);
      if (exp_q0.size() != 0) begin
        e0 = exp_q0.pop_front();
        chk("dut0 result", 64'(res0), e0[63:0]);
        chk("dut0 latency", 64'(cyc), 64'(e0[95:64]));
      end
    end
    pd0 = done0;
  end

  always @(negedge clk) begin
    if (done1) begin
      chk("dut1 done single-cycle", 64'(pd1), 64'd0);
      chk("dut1 done expected", 64'(exp_q1.size() != 0), 64'd1);
      if (exp_q1.size() != 0) begin
        e1 = exp_q1.pop_front();
        chk("dut1 result", 64'(res1), e1[63:0]);
        chk("dut1 latency", 64'(cyc), 64'(e1[95:64]));
      end
    end
    pd1 = done1;
  end

  always @(negedge clk) begin
    if (done2) begin
      chk("dut2 done single-cycle", 64'(pd2), 64'd0);
      chk("dut2 done expected", 64'(exp_q2.size() != 0), 64'd1);
      if (exp_q2.size() != 0) begin
        e2 = exp_q2.pop_front();
        chk("dut2 result", 64'(res2), e2[63:0]);
        chk("dut2 latency", 64'(cyc), 64'(e2[95:64]));
      end
    end
    pd2 = done2;
  end

  always @(negedge clk) begin
    if (done3) begin
      chk("dut3 done single-cycle", 64'(pd3), 64'd0);
      chk("dut3 done expected", 64'(exp_q3.size() != 0), 64'd1);
      if (exp_q3.size() != 0) begin
        e3 = exp_q3.pop_front();
        chk("dut3 result", res3, e3[63:0]);
        chk("dut3 latency", 64'(cyc), 64'(e3[95:64]));
      end
    end
    pd3 = done3;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: request is accepted on the next posedge, so done is
  // seen ITER+1 edges after that, i.e. at cyc + ITER + 2.
  task automatic drive(input logic s0, input logic ss, input logic [1:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic push);
    opc = op; opa = a; opb = b; start0 = s0; start_s = ss;
    if (push) begin
      if (s0) exp_q0.push_back({cyc + 32'd34, model32(op, a[31:0], b[31:0])});
      if (ss) begin
        exp_q1.push_back({cyc + 32'd18, model32(op, a[31:0], b[31:0])});
        exp_q2.push_back({cyc + 32'd10, model32(op, a[31:0], b[31:0])});
        exp_q3.push_back({cyc + 32'd34, model64(op, a, b)});
      end
    end
  endtask

  // Directed request to dut0 with an independently known result.
  task automatic drive0_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
    opc = op; opa = {32'b0, a}; opb = {32'b0, b}; start0 = 1'b1;
    exp_q0.push_back({cyc + 32'd34, 32'b0, exp});
  endtask

  task automatic release_start();
    @(negedge clk);
    start0 = 1'b0; start_s = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()) != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain timeout", 64'(exp_q0.size() + exp_q1.size() + exp_q2.size() + exp_q3.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int base_cnt;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset result", 64'(res0), 64'd0);
    chk("reset done", 64'(done0), 64'd0);
    chk("reset mul_use", 64'(use0), 64'd0);
    chk("reset state", 64'(st0), 64'd0);
    rst = 1'b0;

    // MUL 7 x 0xFFFFFFFD with mul_use trace
    @(negedge clk);
    drive0_exp(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    #1 chk("mul_use accept cycle", 64'(use0), 64'd1);
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      start0 = 1'b0;
      chk("mul_use busy/fix", 64'(use0), 64'd1);
    end
    @(negedge clk);
    chk("mul_use done cycle", 64'(use0), 64'd0);
    chk("done after E33", 64'(done0), 64'd1);
    wait_drain(10);

    // Signed / unsigned high-half corners
    @(negedge clk); drive0_exp(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); release_start(); wait_drain(60);
    @(negedge clk); drive0_exp(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF); release_start(); wait_drain(60);
    @(negedge clk); drive0_exp(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); release_start(); wait_drain(60);
    @(negedge clk); drive0_exp(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); release_start(); wait_drain(60);

    // Flush in BUSY iteration 10 with prior result 0x12345678
    @(negedge clk); drive0_exp(2'b00, 32'h1234_5678, 32'd1, 32'h1234_5678); release_start(); wait_drain(60);
    base_cnt = done_cnt0;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 64'd99, 64'd77, 1'b0);
    release_start();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("flush mul_use next cycle", 64'(use0), 64'd0);
    chk("flush no done", 64'(done0), 64'd0);
    chk("flush result held", 64'(res0), 64'h1234_5678);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    chk("flush result still held", 64'(res0), 64'h1234_5678);
    chk("flush done count", 64'(done_cnt0 - base_cnt), 64'd0);

    // startE held through BUSY and FIX: exactly one operation
    base_cnt = done_cnt0;
    @(negedge clk);
    drive0_exp(2'b00, 32'd1000, 32'd1000, 32'd1_000_000);
    repeat (33) @(negedge clk);
    start0 = 1'b0;
    wait_drain(10);
    repeat (40) @(negedge clk);
    chk("held start single op", 64'(done_cnt0 - base_cnt), 64'd1);

    // Back-to-back: start in the done cycle
    @(negedge clk); drive0_exp(2'b11, 32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD); release_start();
    n = 0;
    while (!done0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("b2b first done seen", 64'(done0), 64'd1);
    drive0_exp(2'b00, 32'd6, 32'd9, 32'd54);
    #1 chk("b2b accept in done cycle", 64'(use0), 64'd1);
    release_start();
    wait_drain(60);

    // Asynchronous reset mid-BUSY
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b00, 64'd11, 64'd13, 1'b0);
    release_start();
    repeat (5) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async reset result", 64'(res0), 64'd0);
    chk("async reset done", 64'(done0), 64'd0);
    chk("async reset mul_use", 64'(use0), 64'd0);
    chk("async reset state", 64'(st0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); drive0_exp(2'b00, 32'd3, 32'd5, 32'd15); release_start(); wait_drain(60);

    // Random sweep across all four configurations
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
      release_start();
      wait_drain(60);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_iterative_param.md
# mul_iterative_param

Parametrised iterative multiplier for the RV32M/RV64M execute stage. It implements MUL, MULH, MULHSU and MULHU with a configurable data width and a configurable number of multiplier bits retired per cycle. Signed operands are handled by magnitude-and-sign correction. The block sits beside the ALU in the execute stage and drives `mul_use` to stall the pipeline while busy. It accepts a pipeline flush that aborts an operation in flight.

## Interface
- `XLEN`, 32: operand and result width. Legal values are 32 or 64.
- `BITS_PER_CYCLE`, 1: multiplier bits consumed per iteration. Legal values are 1, 2 or 4. `XLEN % BITS_PER_CYCLE` must be 0, otherwise elaboration fails.
- `ITER` (localparam): equals `XLEN/BITS_PER_CYCLE`.
- `clk`, in, 1: the block's only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `startE`, in, 1: request a multiply. Sampled only in IDLE.
- `flush`, in, 1: abort the current operation. Has priority over `startE`.
- `mul_opcode`, in, 2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `operand1`, in, XLEN: rs1. Sampled on the accepting edge.
- `operand2`, in, XLEN: rs2. Sampled on the accepting edge.
- `result_multiply`, out, XLEN: registered result. Holds its value until the next completion.
- `done`, out, 1: one-cycle completion pulse, registered.
- `mul_use`, out, 1: stall request, combinational, defined as `(startE & IDLE & ~flush) | BUSY | FIX`.

## Operation
- States: IDLE, BUSY, FIX.
- IDLE:
  - On `startE & ~flush`, latch the opcode.
  - Sign flags:
    - `s1 = operand1[XLEN-1]` for MULH and MULHSU, otherwise 0.
    - `s2 = operand2[XLEN-1]` for MULH only, otherwise 0.
  - Latch `|operand1|` as the unsigned magnitude when `s1` is set, otherwise `operand1`; likewise `|operand2|` with `s2`.
  - Latch `neg = s1 ^ s2`.
  - Clear the 2·XLEN accumulator and the iteration counter, then go to BUSY.
- BUSY, each cycle:
  - Add `mcand_mag * mplier_mag[BITS_PER_CYCLE-1:0]`, shifted left by `counter*BITS_PER_CYCLE`, into the unsigned 2·XLEN accumulator.
  - Shift the multiplier magnitude right by `BITS_PER_CYCLE` and increment the counter.
  - After the `ITER`-th iteration, go to FIX.
- FIX, one cycle:
  - The product is `neg ? -acc : acc`, computed modulo 2^(2·XLEN).
  - `result_multiply` gets `product[XLEN-1:0]` for MUL, otherwise `product[2XLEN-1:XLEN]`.
  - Pulse `done` and return to IDLE.
- The most-negative magnitude (e.g. `0x80000000`) is represented correctly as unsigned XLEN bits. No overflow special case is needed.
- `startE` in BUSY or FIX is ignored. There is no queueing.
- `flush` in BUSY or FIX returns the block to IDLE on the next edge:
  - no `done`;
  - `result_multiply` keeps its old value;
  - `mul_use` falls on that edge.
- `flush` together with `startE` in IDLE: the request is dropped and `mul_use` stays 0.

## Timing
- Reset (asynchronous, any state): state IDLE, `result_multiply = 0`, `done = 0`, accumulator and counter cleared. `mul_use` is 0 once `startE` is low.
- Reset mid-operation discards the operation. No `done` is produced.
- Latency: when `startE` is accepted on edge E0, `done` is high during the cycle following edge E(`ITER`+1), with `result_multiply` valid in that same cycle.
  - XLEN=32, BITS_PER_CYCLE=1: done follows edge E33.
  - BITS_PER_CYCLE=2: E17.
  - BITS_PER_CYCLE=4: E9.
- `mul_use` is high from the accepting cycle, combinationally, through the FIX cycle. It is low during the `done` cycle.
- Back-to-back: a `startE` in the `done` cycle, with state IDLE, is accepted. Throughput is one operation per `ITER`+2 cycles.
- `done` is never high for two consecutive cycles.

## Test plan
- MUL, XLEN=32, BPC=1: 7 × 0xFFFFFFFD → `result_multiply` = 0xFFFFFFEB. `done` follows edge E33, and `mul_use` is high for cycles 0–32.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULH 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- MULHSU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Sweep BITS_PER_CYCLE over 1, 2 and 4, and XLEN=64, with 1000 random operand/opcode pairs each:
  - results match a 2·XLEN reference model;
  - `done` latency equals `ITER`+1 edges exactly.
- Flush and start handling:
  - Assert `flush` in BUSY iteration 10 with a prior result of 0x12345678: no `done`, result stays 0x12345678, `mul_use` is 0 on the next cycle.
  - `startE` held through BUSY produces no second operation.
  - `startE` in the `done` cycle starts a new operation.
- Reset checks:
  - Assert `rst` asynchronously mid-BUSY: outputs go to 0 immediately.
  - A subsequent MUL 3 × 5 → 15 with normal latency.
